// File: rtl/cpu_pkg.sv
// Shared decode definitions for the 9-bit CPU pipeline: instruction classes,
// opcode and special sub-op encodings, and the fixed destination registers.
package cpu_pkg;

  typedef enum logic [2:0] {
    ClsAro  = 3'd0,
    ClsMov  = 3'd1,
    ClsLdst = 3'd2,
    ClsSsb  = 3'd3,
    ClsImm  = 3'd4,
    ClsBr   = 3'd5,
    ClsSpc  = 3'd6,
    ClsIll  = 3'd7
  } op_class_e;

  localparam logic [2:0] OP_ARO  = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_LDST = 3'b010;
  localparam logic [2:0] OP_SSB  = 3'b011;
  localparam logic [2:0] OP_IMM  = 3'b100;
  localparam logic [2:0] OP_BR   = 3'b101;
  localparam logic [2:0] OP_SPC  = 3'b110;
  localparam logic [2:0] OP_TBA  = 3'b111;

  localparam logic [2:0] SPC_RW_A = 3'b001;
  localparam logic [2:0] SPC_RW_B = 3'b100;
  localparam logic [2:0] SPC_RD   = 3'b110;
  localparam logic [2:0] SPC_SYS  = 3'b111;

  localparam logic [3:0] SSB_REG = 4'b1000;
  localparam logic [3:0] IMM_REG = 4'b0001;

endpackage

// File: rtl/decode_fields.sv
// Combinational decode of one instruction word into the register-read bundle,
// plus the next immediate accumulator, bank select and halt request.
module decode_fields
  import cpu_pkg::*;
#(
  parameter int unsigned IW     = 9,
  parameter int unsigned RB     = 3,
  parameter int unsigned BANK_W = 1,
  parameter int unsigned DW     = 8,
  parameter int unsigned OFS_W  = 4
) (
  input  logic [IW-1:0]        instr_i,
  input  logic [BANK_W-1:0]    bank_i,
  input  logic [DW-1:0]        imm_i,
  output op_class_e            op_class_o,
  output logic [2:0]           sub_op_o,
  output logic                 rd1_en_o,
  output logic                 rd2_en_o,
  output logic [BANK_W+RB-1:0] rd1_idx_o,
  output logic [BANK_W+RB-1:0] rd2_idx_o,
  output logic                 wr_en_o,
  output logic [BANK_W+RB-1:0] wr_idx_o,
  output logic [DW-1:0]        imm_o,
  output logic [BANK_W-1:0]    bank_o,
  output logic [DW-1:0]        br_off_o,
  output logic                 br_direct_o,
  output logic                 illegal_o,
  output logic                 halt_o
);

  localparam int unsigned RiW = BANK_W + RB;
  localparam int unsigned LoW = IW - 4;
  localparam int unsigned HiW = DW - LoW;

  logic [2:0]     opc;
  logic [2:0]     sub;
  logic           mode;
  logic [RB-1:0]  ra;
  logic [RB-1:0]  rb;
  logic [RiW-1:0] idx_a;
  logic [RiW-1:0] idx_b;

  assign opc   = instr_i[IW-1 -: 3];
  assign sub   = instr_i[IW-4 -: 3];
  assign mode  = instr_i[IW-4];
  assign ra    = instr_i[2*RB-1:RB];
  assign rb    = instr_i[RB-1:0];
  assign idx_a = {bank_i, ra};
  assign idx_b = {bank_i, rb};

  always_comb begin
    op_class_o  = ClsAro;
    sub_op_o    = '0;
    rd1_en_o    = 1'b0;
    rd2_en_o    = 1'b0;
    rd1_idx_o   = '0;
    rd2_idx_o   = '0;
    wr_en_o     = 1'b0;
    wr_idx_o    = '0;
    imm_o       = imm_i;
    bank_o      = bank_i;
    br_off_o    = '0;
    br_direct_o = 1'b0;
    illegal_o   = 1'b0;
    halt_o      = 1'b0;

    unique case (opc)
      OP_ARO: begin
        op_class_o = ClsAro;
        rd1_idx_o  = idx_a;
        wr_idx_o   = idx_a;
        rd2_idx_o  = idx_b;
        rd1_en_o   = 1'b1;
        rd2_en_o   = 1'b1;
        wr_en_o    = 1'b1;
      end
      OP_MOV: begin
        op_class_o = ClsMov;
        rd1_idx_o  = idx_a;
        rd2_idx_o  = idx_b;
        wr_idx_o   = idx_b;
        rd1_en_o   = 1'b1;
        wr_en_o    = 1'b1;
      end
      OP_LDST: begin
        // The data register is read for a store and written for a load.
        op_class_o = ClsLdst;
        rd1_idx_o  = idx_a;
        rd2_idx_o  = idx_b;
        wr_idx_o   = idx_b;
        rd1_en_o   = 1'b1;
        rd2_en_o   = 1'b1;
        wr_en_o    = 1'b1;
      end
      OP_SSB: begin
        op_class_o = ClsSsb;
        imm_o      = {{HiW{1'b0}}, instr_i[LoW-1:0]};
        bank_o     = instr_i[BANK_W-1:0];
        wr_idx_o   = RiW'(SSB_REG);
        wr_en_o    = 1'b1;
      end
      OP_IMM: begin
        op_class_o = ClsImm;
        if (mode) imm_o = {imm_i[DW-1:LoW], instr_i[LoW-1:0]};
        else      imm_o = {instr_i[HiW-1:0], imm_i[LoW-1:0]};
        wr_idx_o   = RiW'(IMM_REG);
        wr_en_o    = 1'b1;
      end
      OP_BR: begin
        op_class_o = ClsBr;
        if (mode) begin
          br_off_o = {{(DW-OFS_W){instr_i[OFS_W-1]}}, instr_i[OFS_W-1:0]};
        end else begin
          // Direct target names a full register index, not a banked one.
          br_direct_o = 1'b1;
          rd1_idx_o   = instr_i[RiW-1:0];
          rd1_en_o    = 1'b1;
        end
      end
      OP_SPC: begin
        op_class_o = ClsSpc;
        sub_op_o   = sub;
        unique case (sub)
          SPC_RW_A, SPC_RW_B: begin
            rd1_idx_o = idx_b;
            wr_idx_o  = idx_b;
            rd1_en_o  = 1'b1;
            wr_en_o   = 1'b1;
          end
          SPC_RD: begin
            rd1_idx_o = idx_b;
            rd1_en_o  = 1'b1;
          end
          SPC_SYS: begin
            rd2_idx_o = idx_b;
            wr_idx_o  = idx_b;
            if (rb == '0) begin
              halt_o = 1'b1;
            end else begin
              rd2_en_o = 1'b1;
              wr_en_o  = 1'b1;
            end
          end
          default: ;
        endcase
      end
      OP_TBA: begin
        op_class_o = ClsIll;
        illegal_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage_p.sv
// Registered decode stage between fetch and register read: one pipeline
// register with valid/ready on both sides, plus immediate/bank/halt state.
module decode_stage_p
  import cpu_pkg::*;
#(
  parameter int unsigned IW     = 9,
  parameter int unsigned RB     = 3,
  parameter int unsigned BANK_W = 1,
  parameter int unsigned DW     = 8,
  parameter int unsigned OFS_W  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [IW-1:0]        instr_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output op_class_e            op_class_o,
  output logic [2:0]           sub_op_o,
  output logic                 rd1_en_o,
  output logic                 rd2_en_o,
  output logic [BANK_W+RB-1:0] rd1_idx_o,
  output logic [BANK_W+RB-1:0] rd2_idx_o,
  output logic                 wr_en_o,
  output logic [BANK_W+RB-1:0] wr_idx_o,
  output logic [DW-1:0]        imm_o,
  output logic [DW-1:0]        br_off_o,
  output logic                 br_direct_o,
  output logic                 illegal_o,
  output logic                 halted_o
);

  localparam int unsigned RiW = BANK_W + RB;

  typedef struct packed {
    op_class_e      op_class;
    logic [2:0]     sub_op;
    logic           rd1_en;
    logic           rd2_en;
    logic [RiW-1:0] rd1_idx;
    logic [RiW-1:0] rd2_idx;
    logic           wr_en;
    logic [RiW-1:0] wr_idx;
    logic [DW-1:0]  br_off;
    logic           br_direct;
    logic           illegal;
  } bundle_t;

  bundle_t           bundle_d, bundle_q;
  logic              out_valid_d, out_valid_q;
  logic [DW-1:0]     imm_d, imm_q;
  logic [BANK_W-1:0] bank_d, bank_q;
  logic              halted_d, halted_q;
  logic              accept;

  op_class_e         dec_op_class;
  logic [2:0]        dec_sub_op;
  logic              dec_rd1_en, dec_rd2_en, dec_wr_en;
  logic [RiW-1:0]    dec_rd1_idx, dec_rd2_idx, dec_wr_idx;
  logic [DW-1:0]     dec_imm, dec_br_off;
  logic [BANK_W-1:0] dec_bank;
  logic              dec_br_direct, dec_illegal, dec_halt;

  decode_fields #(
    .IW     (IW),
    .RB     (RB),
    .BANK_W (BANK_W),
    .DW     (DW),
    .OFS_W  (OFS_W)
  ) u_fields (
    .instr_i     (instr_i),
    .bank_i      (bank_q),
    .imm_i       (imm_q),
    .op_class_o  (dec_op_class),
    .sub_op_o    (dec_sub_op),
    .rd1_en_o    (dec_rd1_en),
    .rd2_en_o    (dec_rd2_en),
    .rd1_idx_o   (dec_rd1_idx),
    .rd2_idx_o   (dec_rd2_idx),
    .wr_en_o     (dec_wr_en),
    .wr_idx_o    (dec_wr_idx),
    .imm_o       (dec_imm),
    .bank_o      (dec_bank),
    .br_off_o    (dec_br_off),
    .br_direct_o (dec_br_direct),
    .illegal_o   (dec_illegal),
    .halt_o      (dec_halt)
  );

  assign in_ready_o = ~halted_q & (~out_valid_q | out_ready_i);
  assign accept     = in_valid_i & in_ready_o & ~flush_i;

  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    imm_d       = imm_q;
    bank_d      = bank_q;
    halted_d    = halted_q;

    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d        = 1'b1;
      bundle_d.op_class  = dec_op_class;
      bundle_d.sub_op    = dec_sub_op;
      bundle_d.rd1_en    = dec_rd1_en;
      bundle_d.rd2_en    = dec_rd2_en;
      bundle_d.rd1_idx   = dec_rd1_idx;
      bundle_d.rd2_idx   = dec_rd2_idx;
      bundle_d.wr_en     = dec_wr_en;
      bundle_d.wr_idx    = dec_wr_idx;
      bundle_d.br_off    = dec_br_off;
      bundle_d.br_direct = dec_br_direct;
      bundle_d.illegal   = dec_illegal;
      imm_d              = dec_imm;
      bank_d             = dec_bank;
      halted_d           = halted_q | dec_halt;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      imm_q       <= '0;
      bank_q      <= '0;
      halted_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
      imm_q       <= imm_d;
      bank_q      <= bank_d;
      halted_q    <= halted_d;
    end
  end

  // imm_q only moves on accept, so it always equals the held bundle's imm.
  assign out_valid_o = out_valid_q;
  assign op_class_o  = bundle_q.op_class;
  assign sub_op_o    = bundle_q.sub_op;
  assign rd1_en_o    = bundle_q.rd1_en;
  assign rd2_en_o    = bundle_q.rd2_en;
  assign rd1_idx_o   = bundle_q.rd1_idx;
  assign rd2_idx_o   = bundle_q.rd2_idx;
  assign wr_en_o     = bundle_q.wr_en;
  assign wr_idx_o    = bundle_q.wr_idx;
  assign imm_o       = imm_q;
  assign br_off_o    = bundle_q.br_off;
  assign br_direct_o = bundle_q.br_direct;
  assign illegal_o   = bundle_q.illegal;
  assign halted_o    = halted_q;

endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: directed vector table, handshake corner sequences,
// and a randomized run against a rule-level reference model.
module tb_decode_stage_p;
  import cpu_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [8:0] instr_i;
  logic       flush_i;
  logic       out_valid_o;
  logic       out_ready_i;
  op_class_e  op_class_o;
  logic [2:0] sub_op_o;
  logic       rd1_en_o, rd2_en_o, wr_en_o;
  logic [3:0] rd1_idx_o, rd2_idx_o, wr_idx_o;
  logic [7:0] imm_o, br_off_o;
  logic       br_direct_o, illegal_o, halted_o;

  decode_stage_p u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .instr_i     (instr_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .op_class_o  (op_class_o),
    .sub_op_o    (sub_op_o),
    .rd1_en_o    (rd1_en_o),
    .rd2_en_o    (rd2_en_o),
    .rd1_idx_o   (rd1_idx_o),
    .rd2_idx_o   (rd2_idx_o),
    .wr_en_o     (wr_en_o),
    .wr_idx_o    (wr_idx_o),
    .imm_o       (imm_o),
    .br_off_o    (br_off_o),
    .br_direct_o (br_direct_o),
    .illegal_o   (illegal_o),
    .halted_o    (halted_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [2:0] cls;
    logic [2:0] sub;
    logic       e1, e2, ew;
    logic [3:0] i1, i2, iw;
    logic [7:0] imm;
    logic [7:0] off;
    logic       dir;
    logic       ill;
  } obs_t;

  typedef struct {
    logic [8:0] instr;
    obs_t       exp;
  } vec_t;

  int errors = 0;
  int checks = 0;

  obs_t m_obs;
  bit   m_valid, m_halted;
  int   m_imm, m_bank;

  localparam logic [8:0] ARO  = 9'b000_010_011;
  localparam logic [8:0] HALT = 9'b110_111_000;

  function automatic obs_t mk(input logic [2:0] cls, input logic [2:0] sub, input logic e1,
                              input logic e2, input logic ew, input logic [3:0] i1,
                              input logic [3:0] i2, input logic [3:0] iw, input logic [7:0] imm,
                              input logic [7:0] off, input logic dir, input logic ill);
    return '{cls: cls, sub: sub, e1: e1, e2: e2, ew: ew, i1: i1, i2: i2, iw: iw,
             imm: imm, off: off, dir: dir, ill: ill};
  endfunction

  function automatic obs_t observe();
    return '{cls: op_class_o, sub: sub_op_o, e1: rd1_en_o, e2: rd2_en_o, ew: wr_en_o,
             i1: rd1_idx_o, i2: rd2_idx_o, iw: wr_idx_o, imm: imm_o, off: br_off_o,
             dir: br_direct_o, ill: illegal_o};
  endfunction

  // Reference decode written straight from the opcode rules using integer arithmetic.
  function automatic obs_t model_dec(input logic [8:0] ins, input int bank, input int imm_in,
                                     output int imm_out, output int bank_out, output bit halt);
    obs_t o;
    int v, op, ra, rb, mode, off;
    v = int'(ins);
    op = v / 64; ra = (v / 8) % 8; rb = v % 8; mode = (v / 32) % 2;
    o = '0;
    o.cls = 3'(op);
    imm_out = imm_in; bank_out = bank; halt = 0;
    case (op)
      0: begin
        o.i1 = 4'(bank * 8 + ra); o.iw = o.i1; o.i2 = 4'(bank * 8 + rb);
        o.e1 = 1; o.e2 = 1; o.ew = 1;
      end
      1, 2: begin
        o.i1 = 4'(bank * 8 + ra); o.i2 = 4'(bank * 8 + rb); o.iw = o.i2;
        o.e1 = 1; o.ew = 1; o.e2 = (op == 2);
      end
      3: begin
        imm_out = v % 32; bank_out = v % 2; o.iw = 4'd8; o.ew = 1;
      end
      4: begin
        if (mode == 1) imm_out = (imm_in / 32) * 32 + v % 32;
        else           imm_out = (v % 8) * 32 + imm_in % 32;
        o.iw = 4'd1; o.ew = 1;
      end
      5: begin
        if (mode == 1) begin
          off = v % 16;
          if (off >= 8) off = off - 16;
          o.off = 8'(off);
        end else begin
          o.dir = 1; o.i1 = 4'(v % 16); o.e1 = 1;
        end
      end
      6: begin
        o.sub = 3'(ra);
        if (ra == 1 || ra == 4) begin
          o.i1 = 4'(bank * 8 + rb); o.iw = o.i1; o.e1 = 1; o.ew = 1;
        end else if (ra == 6) begin
          o.i1 = 4'(bank * 8 + rb); o.e1 = 1;
        end else if (ra == 7) begin
          o.i2 = 4'(bank * 8 + rb); o.iw = o.i2;
          if (rb == 0) halt = 1;
          else begin o.e2 = 1; o.ew = 1; end
        end
      end
      default: o.ill = 1;
    endcase
    o.imm = 8'(imm_out);
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [8:0] ins, input logic rdy, input logic fl);
    in_valid_i = v; instr_i = ins; out_ready_i = rdy; flush_i = fl;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(1'b0, 9'd0, 1'b0, 1'b0);
    tick(); tick();
    rst_i = 1'b0;
  endtask

  vec_t tbl[13];

  initial begin
    obs_t e_aro, e_halt;
    int   ni, nb;
    bit   nh, acc, exp_rdy;

    tbl[0]  = '{ARO,          mk(3'd0, 3'd0, 1, 1, 1, 4'b0010, 4'b0011, 4'b0010, 8'h00, 8'h00, 0, 0)};
    tbl[1]  = '{9'b100110101, mk(3'd4, 3'd0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0001, 8'h15, 8'h00, 0, 0)};
    tbl[2]  = '{9'b100000110, mk(3'd4, 3'd0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0001, 8'hD5, 8'h00, 0, 0)};
    tbl[3]  = '{9'b011000001, mk(3'd3, 3'd0, 0, 0, 1, 4'b0000, 4'b0000, 4'b1000, 8'h01, 8'h00, 0, 0)};
    tbl[4]  = '{9'b001000111, mk(3'd1, 3'd0, 1, 0, 1, 4'b1000, 4'b1111, 4'b1111, 8'h01, 8'h00, 0, 0)};
    tbl[5]  = '{9'b101101110, mk(3'd5, 3'd0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h01, 8'hFE, 0, 0)};
    tbl[6]  = '{9'b101000101, mk(3'd5, 3'd0, 1, 0, 0, 4'b0101, 4'b0000, 4'b0000, 8'h01, 8'h00, 1, 0)};
    tbl[7]  = '{9'b010011100, mk(3'd2, 3'd0, 1, 1, 1, 4'b1011, 4'b1100, 4'b1100, 8'h01, 8'h00, 0, 0)};
    tbl[8]  = '{9'b110001010, mk(3'd6, 3'd1, 1, 0, 1, 4'b1010, 4'b0000, 4'b1010, 8'h01, 8'h00, 0, 0)};
    tbl[9]  = '{9'b110110011, mk(3'd6, 3'd6, 1, 0, 0, 4'b1011, 4'b0000, 4'b0000, 8'h01, 8'h00, 0, 0)};
    tbl[10] = '{9'b110111101, mk(3'd6, 3'd7, 0, 1, 1, 4'b0000, 4'b1101, 4'b1101, 8'h01, 8'h00, 0, 0)};
    tbl[11] = '{9'b110010101, mk(3'd6, 3'd2, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h01, 8'h00, 0, 0)};
    tbl[12] = '{9'b111101010, mk(3'd7, 3'd0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h01, 8'h00, 0, 1)};
    e_aro  = tbl[0].exp;
    e_halt = mk(3'd6, 3'd7, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00, 0, 0);

    // Reset state
    do_reset();
    #1;
    chk("rst_out_valid", 64'(out_valid_o), 64'(1'b0));
    chk("rst_in_ready", 64'(in_ready_o), 64'(1'b1));
    chk("rst_halted", 64'(halted_o), 64'(1'b0));
    chk("rst_bundle", 64'(observe()), 64'(obs_t'('0)));

    // Directed table, back-to-back accepts with the consumer always ready
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, tbl[i].instr, 1'b1, 1'b0);
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(out_valid_o), 64'(1'b1));
      chk($sformatf("vec%0d_bundle", i), 64'(observe()), 64'(tbl[i].exp));
    end

    // Backpressure: bundle holds, incoming Lo is not taken, then released
    do_reset();
    drive(1'b1, ARO, 1'b0, 1'b0);
    tick();
    chk("bp_load_valid", 64'(out_valid_o), 64'(1'b1));
    drive(1'b1, 9'b100111111, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", 64'(in_ready_o), 64'(1'b0));
      tick();
      chk("bp_valid", 64'(out_valid_o), 64'(1'b1));
      chk("bp_hold", 64'(observe()), 64'(e_aro));
    end
    drive(1'b1, 9'b100111111, 1'b1, 1'b0);
    #1;
    chk("bp_release_ready", 64'(in_ready_o), 64'(1'b1));
    tick();
    chk("bp_new", 64'(observe()),
        64'(mk(3'd4, 3'd0, 0, 0, 1, 4'd0, 4'd0, 4'b0001, 8'h1F, 8'h00, 0, 0)));
    drive(1'b0, 9'd0, 1'b1, 1'b0);
    tick();
    chk("bp_drain", 64'(out_valid_o), 64'(1'b0));

    // Flush drops the incoming Hi; a following Lo then shows hi bits untouched
    drive(1'b1, 9'b100000111, 1'b1, 1'b1);
    tick();
    chk("flush_in_valid", 64'(out_valid_o), 64'(1'b0));
    drive(1'b1, 9'b100100000, 1'b1, 1'b0);
    tick();
    chk("flush_in_state", 64'(observe()),
        64'(mk(3'd4, 3'd0, 0, 0, 1, 4'd0, 4'd0, 4'b0001, 8'h00, 8'h00, 0, 0)));

    // Reset while a bundle is being held
    drive(1'b1, ARO, 1'b0, 1'b0);
    tick();
    chk("rstmid_loaded", 64'(out_valid_o), 64'(1'b1));
    rst_i = 1'b1;
    drive(1'b0, 9'd0, 1'b0, 1'b0);
    tick();
    rst_i = 1'b0;
    chk("rstmid_valid", 64'(out_valid_o), 64'(1'b0));
    chk("rstmid_bundle", 64'(observe()), 64'(obs_t'('0)));

    // HALT drains normally, then no further accepts
    drive(1'b1, HALT, 1'b1, 1'b0);
    tick();
    chk("halt_valid", 64'(out_valid_o), 64'(1'b1));
    chk("halt_bundle", 64'(observe()), 64'(e_halt));
    chk("halt_sticky", 64'(halted_o), 64'(1'b1));
    drive(1'b1, ARO, 1'b1, 1'b0);
    #1;
    chk("halt_in_ready", 64'(in_ready_o), 64'(1'b0));
    tick();
    chk("halt_drained", 64'(out_valid_o), 64'(1'b0));

    // HALT held, flush with out_ready, then reset restores everything
    do_reset();
    drive(1'b1, HALT, 1'b0, 1'b0);
    tick();
    chk("hf_valid", 64'(out_valid_o), 64'(1'b1));
    drive(1'b1, ARO, 1'b1, 1'b1);
    tick();
    chk("hf_flushed", 64'(out_valid_o), 64'(1'b0));
    chk("hf_halted", 64'(halted_o), 64'(1'b1));
    drive(1'b1, ARO, 1'b1, 1'b0);
    #1;
    chk("hf_in_ready", 64'(in_ready_o), 64'(1'b0));
    tick();
    chk("hf_no_accept", 64'(out_valid_o), 64'(1'b0));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    drive(1'b0, 9'd0, 1'b0, 1'b0);
    #1;
    chk("hf_rst_halted", 64'(halted_o), 64'(1'b0));
    chk("hf_rst_in_ready", 64'(in_ready_o), 64'(1'b1));
    chk("hf_rst_bundle", 64'(observe()), 64'(obs_t'('0)));

    // Randomized run against the reference model
    do_reset();
    m_valid = 0; m_halted = 0; m_imm = 0; m_bank = 0; m_obs = '0;
    for (int c = 0; c < 3000; c++) begin
      rst_i = ($urandom_range(0, 149) == 0);
      drive(($urandom_range(0, 3) != 0), 9'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0));
      #1;
      exp_rdy = !m_halted && (!m_valid || out_ready_i);
      chk("rnd_in_ready", 64'(in_ready_o), 64'(exp_rdy));
      @(posedge clk_i);
      if (rst_i) begin
        m_valid = 0; m_halted = 0; m_imm = 0; m_bank = 0; m_obs = '0;
      end else begin
        acc = in_valid_i && exp_rdy && !flush_i;
        if (flush_i) begin
          m_valid = 0;
        end else if (acc) begin
          m_obs = model_dec(instr_i, m_bank, m_imm, ni, nb, nh);
          m_valid = 1; m_imm = ni; m_bank = nb;
          if (nh) m_halted = 1;
        end else if (out_ready_i) begin
          m_valid = 0;
        end
      end
      #1;
      chk("rnd_out_valid", 64'(out_valid_o), 64'(m_valid));
      chk("rnd_halted", 64'(halted_o), 64'(m_halted));
      if (m_valid) chk("rnd_bundle", 64'(observe()), 64'(m_obs));
    end
    rst_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
